// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt mask register: register address map and source count.
package interrupt_pkg;

  localparam int NUM_INTS = 7;

  localparam logic [1:0] INT_MASK = 2'b00;
  localparam logic [1:0] INT_INTS = 2'b01;
  localparam logic [1:0] INT_PRI  = 2'b10;

  // Bit 0 of the mask and pending vectors does not correspond to a source.
  localparam logic [7:0] SRC_BITS = 8'hFE;

endpackage

// File: rtl/int_priority_encoder.sv
// Combinational priority encoder: returns the lowest set index of pending[7:1], 0 when none.
module int_priority_encoder (
  input  logic [7:0] pending,
  output logic [2:0] pri
);

  // NOTE: assigning a default before any conditional update keeps always_comb from inferring a latch.
  always_comb begin
    pri = 3'd0;
    // Scan from lowest priority upward so the lowest set index wins.
    for (int i = 7; i >= 0; i--) begin
      if (i != 0 && pending[i]) pri = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_mask_register.sv
// Interrupt mask register: masks seven level sources into one CPU interrupt with a small register file.
// Define INT_SYNC_EN to pass each source through a 2-flop synchroniser before masking.
module interrupt_mask_register
  import interrupt_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DIN,
  input  logic        RD,
  input  logic        WR,
  input  logic [1:0]  ADDR,
  input  logic        INTS1,
  input  logic        INTS2,
  input  logic        INTS3,
  input  logic        INTS4,
  input  logic        INTS5,
  input  logic        INTS6,
  input  logic        INTS7,
  output logic [15:0] DOUT,
  output logic        INT1
);

  logic [NUM_INTS:1] ints_raw;
  logic [NUM_INTS:1] ints_s;
  logic [7:0]        mask;
  logic [7:0]        pending;
  logic [7:0]        pending_d;
  logic [2:0]        pri;

  assign ints_raw = {INTS7, INTS6, INTS5, INTS4, INTS3, INTS2, INTS1};

`ifdef INT_SYNC_EN
  logic [NUM_INTS:1] sync1;
  logic [NUM_INTS:1] sync2;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ints_raw;
      sync2 <= sync1;
    end
  end

  assign ints_s = sync2;
`else
  assign ints_s = ints_raw;
`endif

  // Bit 0 of mask is held at zero, so pending[0] can never be set.
  assign pending_d = {ints_s, 1'b0} & mask;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mask    <= '0;
      pending <= '0;
      INT1    <= 1'b0;
    end else begin
      if (WR && ADDR == INT_MASK) mask <= DIN & SRC_BITS;
      pending <= pending_d;
      // INT1 is registered from the same next-state as pending so it never lags it.
      INT1    <= |pending_d;
    end
  end

  int_priority_encoder u_pri (
    .pending (pending),
    .pri     (pri)
  );

  always_comb begin
    DOUT = 16'h0000;
    if (RD) begin
      unique case (ADDR)
        INT_MASK: DOUT = {8'h00, mask};
        INT_INTS: DOUT = {8'h00, pending};
        INT_PRI:  DOUT = {13'h0000, pri};
        default:  DOUT = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_mask_register.sv
// Self-checking bench for interrupt_mask_register (INT_SYNC_EN undefined): directed and random stimulus
// compared against a cycle-level reference model of mask/pending state.
module tb_interrupt_mask_register;
  import interrupt_pkg::*;

  logic        CLK;
  logic        RESET;
  logic [7:0]  DIN;
  logic        RD;
  logic        WR;
  logic [1:0]  ADDR;
  logic [7:1]  ints;
  logic [15:0] DOUT;
  logic        INT1;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] m_mask;
  logic [7:0] m_pend;

  interrupt_mask_register dut (
    .CLK   (CLK),
    .RESET (RESET),
    .DIN   (DIN),
    .RD    (RD),
    .WR    (WR),
    .ADDR  (ADDR),
    .INTS1 (ints[1]),
    .INTS2 (ints[2]),
    .INTS3 (ints[3]),
    .INTS4 (ints[4]),
    .INTS5 (ints[5]),
    .INTS6 (ints[6]),
    .INTS7 (ints[7]),
    .DOUT  (DOUT),
    .INT1  (INT1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int model_pri(input logic [7:0] p);
    int r;
    r = 0;
    for (int n = 7; n >= 1; n--) if (p[n]) r = n;
    return r;
  endfunction

  function automatic logic [15:0] model_read(input logic [1:0] a);
    case (a)
      2'b00:   return {8'h00, m_mask};
      2'b01:   return {8'h00, m_pend};
      2'b10:   return 16'(model_pri(m_pend));
      default: return 16'h0000;
    endcase
  endfunction

  // Advance one clock; the model takes the inputs as they stand before the edge.
  task automatic tick();
    logic [7:0] nxt_mask;
    logic [7:0] nxt_pend;
    nxt_pend = {ints, 1'b0} & m_mask;
    nxt_mask = m_mask;
    if (WR && ADDR == 2'b00) nxt_mask = {DIN[7:1], 1'b0};
    @(posedge CLK);
    #1;
    m_mask = nxt_mask;
    m_pend = nxt_pend;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DIN = d;
    tick();
    WR = 1'b0; DIN = 8'h00;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
    RD = 1'b1; ADDR = a;
    #1;
    d = DOUT;
    RD = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    RESET = 1'b0; ints = '1;
    #3;
    checks++;
    if (INT1 !== 1'b0) begin errors++; $display("FAIL reset_int1 got %b want 0", INT1); end
    RESET = 1'b1;
    m_mask = 8'h00; m_pend = 8'h00;
    tick(); tick();
    checks++;
    if (INT1 !== 1'b0) begin errors++; $display("FAIL mask0_int1 got %b want 0", INT1); end
    read_reg(INT_INTS, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL mask0_ints got %h want 0000", d); end
    read_reg(INT_PRI, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL mask0_pri got %h want 0000", d); end
  endtask

  task automatic test_mask_walk();
    logic [15:0] d;
    logic [7:0]  masks [7];
    masks = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE};
    for (int k = 0; k < 7; k++) begin
      write_reg(INT_MASK, masks[k]);
      tick();
      checks++;
      if (INT1 !== 1'b1) begin errors++; $display("FAIL walk_int1 mask %h got %b want 1", masks[k], INT1); end
      read_reg(INT_INTS, d);
      checks++;
      if (d !== {8'h00, masks[k]}) begin errors++; $display("FAIL walk_ints mask %h got %h want %h", masks[k], d, {8'h00, masks[k]}); end
      read_reg(INT_PRI, d);
      checks++;
      if (d !== 16'(7 - k)) begin errors++; $display("FAIL walk_pri mask %h got %h want %0d", masks[k], d, 7 - k); end
    end
  endtask

  task automatic test_drop();
    logic [15:0] d;
    ints = '0;
    tick();
    checks++;
    if (INT1 !== 1'b0) begin errors++; $display("FAIL drop_int1 got %b want 0", INT1); end
    read_reg(INT_INTS, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL drop_ints got %h want 0000", d); end
    read_reg(INT_PRI, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL drop_pri got %h want 0000", d); end
  endtask

  task automatic test_reserved();
    logic [15:0] d;
    write_reg(INT_MASK, 8'h00);
    write_reg(INT_PRI, 8'hFF);
    write_reg(2'b11, 8'hFF);
    write_reg(INT_MASK, 8'h01);
    read_reg(INT_MASK, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reserved_mask got %h want 0000", d); end
    write_reg(INT_MASK, 8'h5A);
    read_reg(2'b11, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reserved_read got %h want 0000", d); end
    ADDR = INT_MASK; RD = 1'b0;
    #1;
    checks++;
    if (DOUT !== 16'h0000) begin errors++; $display("FAIL rd_low got %h want 0000", DOUT); end
  endtask

  task automatic test_rd_wr();
    RD = 1'b1; WR = 1'b1; ADDR = INT_MASK; DIN = 8'hA5;
    #1;
    checks++;
    if (DOUT !== 16'h005A) begin errors++; $display("FAIL rdwr_old got %h want 005a", DOUT); end
    tick();
    WR = 1'b0;
    checks++;
    if (DOUT !== 16'h00A4) begin errors++; $display("FAIL rdwr_new got %h want 00a4", DOUT); end
    RD = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int c = 0; c < 300; c++) begin
      ints = 7'($urandom);
      WR   = ($urandom_range(0, 3) == 0);
      DIN  = 8'($urandom);
      ADDR = 2'($urandom);
      RD   = 1'($urandom);
      #1;
      exp = RD ? model_read(ADDR) : 16'h0000;
      checks++;
      if (DOUT !== exp) begin errors++; $display("FAIL rand_dout cyc %0d addr %0d got %h want %h", c, ADDR, DOUT, exp); end
      checks++;
      if (INT1 !== (m_pend != 8'h00)) begin errors++; $display("FAIL rand_int1 cyc %0d got %b want %b", c, INT1, m_pend != 8'h00); end
      tick();
    end
    WR = 1'b0; RD = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    ints = 7'b0000100;
    write_reg(INT_MASK, 8'hFE);
    tick();
    checks++;
    if (INT1 !== 1'b1) begin errors++; $display("FAIL prereset_int1 got %b want 1", INT1); end
    RD = 1'b1; ADDR = INT_INTS;
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (INT1 !== 1'b0) begin errors++; $display("FAIL async_int1 got %b want 0", INT1); end
    checks++;
    if (DOUT !== 16'h0000) begin errors++; $display("FAIL async_dout got %h want 0000", DOUT); end
    RD = 1'b0;
    #1;
    RESET = 1'b1;
    m_mask = 8'h00; m_pend = 8'h00;
    tick();
    read_reg(INT_MASK, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL postreset_mask got %h want 0000", d); end
  endtask

  initial begin
    RESET = 1'b0; DIN = 8'h00; RD = 1'b0; WR = 1'b0; ADDR = 2'b00; ints = '0;
    m_mask = 8'h00; m_pend = 8'h00;
    test_reset();
    test_mask_walk();
    test_drop();
    test_reserved();
    test_rd_wr();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
